// File: rtl/uart_pkg.sv
// Shared definitions for the decimal UART transmitter: FSM states, ASCII constants, bit period.
// The parity state exists only when UART_DEC_TX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_DEC_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle, StConv, StLoad, StStart, StData, StParity, StStop
  } state_t;
`else
  typedef enum logic [2:0] {
    StIdle, StConv, StLoad, StStart, StData, StStop
  } state_t;
`endif

  typedef enum logic [1:0] {PhDigit, PhCr, PhLf} phase_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic int unsigned bit_period(int unsigned clk_freq, int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_bin2bcd.sv
// Sequential double-dabble: one input bit per cycle, DATA_W cycles, done pulses with the last step.
module uart_bin2bcd #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       value,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  logic [DATA_W-1:0]       bin_q;
  logic [4*NUM_DIGITS-1:0] bcd_q, adj, bcd_d;
  logic [5:0]              cnt_q;
  logic                    run_q;

  // Carry out of the top digit is dropped, so the result is the value modulo 10^NUM_DIGITS.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = (adj << 1) | {{(4*NUM_DIGITS-1){1'b0}}, bin_q[DATA_W-1]};
  end

  assign done = run_q && (cnt_q == 6'd1);
  assign bcd  = bcd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      bin_q <= value;
      bcd_q <= '0;
      cnt_q <= 6'(DATA_W);
      run_q <= 1'b1;
    end else if (run_q) begin
      bin_q <= {bin_q[DATA_W-2:0], 1'b0};
      bcd_q <= bcd_d;
      cnt_q <= cnt_q - 6'd1;
      if (cnt_q == 6'd1) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_dec_tx.sv
// Prints an unsigned value as decimal ASCII plus terminator on a UART line.
// Optional even parity bit selected by macro UART_DEC_TX_PARITY_EN.
module uart_dec_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 12000000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned NUM_DIGITS    = 3,
  parameter int unsigned ZERO_SUPPRESS = 0,
  parameter int unsigned CRLF          = 0,
  parameter int unsigned STOP_BITS     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned CPB   = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W = $clog2(CPB + 1);
  localparam logic [3:0]  MSD   = 4'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  phase_t                  phase_q, phase_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              bit_q, bit_d;
  logic                    stop_q, stop_d;
  logic [7:0]              char_q, char_d;
  logic [3:0]              pos_q, pos_d;
  logic                    first_q, first_d, last_q, last_d;
  logic                    accept, conv_done, bit_end;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [3:0]              msd_idx, cur_idx, cur_digit;

  uart_bin2bcd #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .start(accept),
    .value(data_in),
    .done (conv_done),
    .bcd  (bcd)
  );

  assign ready   = (state_q == StIdle);
  assign busy    = ~ready;
  assign accept  = valid & ready;
  assign bit_end = (cnt_q == CNT_W'(CPB - 1));

  always_comb begin
    msd_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd_idx = 4'(i);
    end
    cur_idx = first_q ? ((ZERO_SUPPRESS != 0) ? msd_idx : MSD) : pos_q;
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cur_idx == 4'(i)) cur_digit = bcd[4*i +: 4];
    end
  end

  // The LOAD cycle is already the first clock of the start bit, so frames abut.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      StLoad, StStart: tx = 1'b0;
      StData:          tx = char_q[bit_q];
`ifdef UART_DEC_TX_PARITY_EN
      StParity:        tx = ^char_q;
`endif
      default:         tx = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    char_d  = char_q;
    pos_d   = pos_q;
    first_d = first_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StConv;
          phase_d = PhDigit;
          pos_d   = '0;
          first_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      StConv: begin
        if (conv_done) state_d = StLoad;
      end
      StLoad: begin
        state_d = StStart;
        cnt_d   = CNT_W'(1);
        first_d = 1'b0;
        case (phase_q)
          PhDigit: begin
            char_d = ASCII_ZERO + {4'd0, cur_digit};
            if (cur_idx == 4'd0) phase_d = (CRLF != 0) ? PhCr : PhLf;
            else                 pos_d   = cur_idx - 4'd1;
          end
          PhCr: begin
            char_d  = ASCII_CR;
            phase_d = PhLf;
          end
          default: begin
            char_d = ASCII_LF;
            last_d = 1'b1;
          end
        endcase
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
`ifdef UART_DEC_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_DEC_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (STOP_BITS == 2 && !stop_q) stop_d  = 1'b1;
          else if (last_q)               state_d = StIdle;
          else                           state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= PhDigit;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      char_q  <= '0;
      pos_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      char_q  <= char_d;
      pos_q   <= pos_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

endmodule
